ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
//  Instruction fetch stage: drives the instruction memory and feeds the decode stage over its
//  v/stall handshake, i.e. the transmitter side of the IF->ID interface. Holds the PC, issues one
//  word read per cycle to a synchronous imem (1-cycle latency), buffers in-flight data during
//  ID back-pressure, and redirects on taken branches from EX.
// PARAMETERS
//  WORD      32  instruction/data width (from include/params.vh)
//  W_ADDR    16  imem word-address width
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk          in   1       clock, single domain
//  rst          in   1       synchronous, active-high reset
//  imem_req_o   out  1       read strobe; data returned next cycle
//  imem_addr_o  out  W_ADDR  word address of the read
//  imem_data_i  in   WORD    read data, valid the cycle after imem_req_o
//  br_taken_i   in   1       1-cycle redirect pulse from EX
//  br_target_i  in   W_ADDR  redirect address
//  v_o          out  1       inst_o valid to ID
//  inst_o       out  WORD    fetched instruction
//  stall_i      in   1       ID hold request; asserted only while v_o=1
//  pc_o         out  W_ADDR  address of inst_o (IFETCH_PC_OUT_EN only)
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc=RESET_PC, v_o=0, inst_o=0, imem_req_o=0, imem_addr_o=RESET_PC,
//   rsp_v=0, skid_v=0. Reset in mid-operation discards all in-flight/buffered words.
//  accept = ~v_o | ~stall_i. issue = accept & ~br_taken_i & ~rst; imem_req_o=issue, imem_addr_o=pc.
//  On issue: pc <= pc+1 (mod 2^W_ADDR, FFFF wraps to 0000); rsp_v/rsp_pc set for next cycle.
//  Output register loads when accept: from skid if skid_v (skid_v<=0), else imem_data_i if rsp_v,
//   else v_o<=0. While ~accept: v_o/inst_o/pc_o held stable; rsp_v word goes to skid (skid_v<=1).
//  Invariant: rsp_v & skid_v never both 1 (no issue while ~accept); assert in sim.
//  Latency: req at cycle N -> v_o=1 at N+2; first req cycle after rst deasserts, first v_o 2 later.
//  Steady state no stall: one instruction per cycle, no bubbles; stall release: no bubble (skid drains).
//  Branch (br_taken_i=1, overrides stall): no issue that cycle; pc<=br_target_i; v_o<=0;
//   skid_v<=0; current rsp_v killed (its data never reaches v_o). Target issued next cycle,
//   v_o for target 2 cycles later. br_taken_i concurrent with rst: rst wins.
//  States implicit in {v_o,rsp_v,skid_v}: EMPTY, RUN, HOLD(skid full); no separate FSM register.
// CONFIGURATION
//  IFETCH_PC_OUT_EN defined: pc_o port present, carries PC of inst_o, held/flushed with it, reset
//   RESET_PC. Undefined: no pc_o port, no PC pipeline/skid copy; all other behaviour identical.
// STRUCTURE
//  Shared package (include/params.vh): WORD, W_ADDR, RESET_PC default, instruction field
//   positions used by ID. No typedefs needed.
//  One natural sub-module: ifetch_skid (1-entry {data,pc} buffer with load/drain/flush);
//   PC, issue and output register stay in ifetch.
// TESTING
//  1 rst 2 cycles, imem returns addr+0x100, stall_i=0 -> req addrs 0,1,2..; v_o first 2 cycles
//    after rst low; inst_o = 0x100,0x101,.. one per cycle.
//  2 stall_i=1 for 3 cycles while inst_o=0x103 -> inst_o held 0x103, exactly one word in skid,
//    no req during stall; after release 0x104,0x105 back-to-back, none lost/duplicated.
//  3 br_taken_i=1 target 0x0040 while fetching 5 -> words 5,6 never valid; next req 0x0040,
//    v_o=0 for 2 cycles, then inst_o=0x140.
//  4 branch during stall with skid full -> stall ignored, skid flushed, inst for 0x0040 delivered.
//  5 RESET_PC=0xFFFE -> addrs FFFE,FFFF,0000,0001; no X on imem_addr_o.
//  6 rst pulsed mid-stall -> next cycle v_o=0, skid empty, req restarts at RESET_PC.
//  Each run with and without IFETCH_PC_OUT_EN; with it, check pc_o tracks inst_o address.

Source files
------------

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared widths, reset PC default and instruction field positions for IF/ID
package ifetch_pkg;

  localparam int IF_WORD     = 32;
  localparam int IF_W_ADDR   = 16;
  localparam int IF_RESET_PC = 0;

  // Instruction field positions decoded by ID
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 7;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_W   = 3;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int REG_W      = 5;

endpackage

// File: rtl/ifetch_skid.sv
// rtl/ifetch_skid.sv - one-entry holding buffer for a word returned while ID stalls
// Optional pc copy under IFETCH_PC_OUT_EN.
module ifetch_skid
  import ifetch_pkg::*;
#(
  parameter int WORD   = IF_WORD
`ifdef IFETCH_PC_OUT_EN
  ,
  parameter int W_ADDR = IF_W_ADDR
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic [WORD-1:0]   data_i,
`ifdef IFETCH_PC_OUT_EN
  input  logic [W_ADDR-1:0] pc_i,
  output logic [W_ADDR-1:0] pc_o,
`endif
  output logic              v_o,
  output logic [WORD-1:0]   data_o
);

  logic            v_q, v_d;
  logic [WORD-1:0] data_q, data_d;
`ifdef IFETCH_PC_OUT_EN
  logic [W_ADDR-1:0] pc_q, pc_d;
`endif

  // Flush beats load: a redirect discards whatever was returning that cycle
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
`ifdef IFETCH_PC_OUT_EN
    pc_d   = pc_q;
`endif
    if (flush_i || drain_i) begin
      v_d = 1'b0;
    end else if (load_i) begin
      v_d    = 1'b1;
      data_d = data_i;
`ifdef IFETCH_PC_OUT_EN
      pc_d   = pc_i;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
`ifdef IFETCH_PC_OUT_EN
      pc_q   <= '0;
`endif
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
`ifdef IFETCH_PC_OUT_EN
      pc_q   <= pc_d;
`endif
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
`ifdef IFETCH_PC_OUT_EN
  assign pc_o   = pc_q;
`endif

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: PC, imem read issue, IF->ID output register with skid
// IFETCH_PC_OUT_EN adds the pc_o port and its pipeline copy.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int          WORD     = IF_WORD,
  parameter int          W_ADDR   = IF_W_ADDR,
  parameter int unsigned RESET_PC = IF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [W_ADDR-1:0] imem_addr_o,
  input  logic [WORD-1:0]   imem_data_i,
  input  logic              br_taken_i,
  input  logic [W_ADDR-1:0] br_target_i,
  output logic              v_o,
  output logic [WORD-1:0]   inst_o,
`ifdef IFETCH_PC_OUT_EN
  output logic [W_ADDR-1:0] pc_o,
`endif
  input  logic              stall_i
);

  localparam logic [W_ADDR-1:0] RST_PC = W_ADDR'(RESET_PC);

  logic [W_ADDR-1:0] pc_q, pc_d;
  logic              rsp_v_q, rsp_v_d;
  logic              v_q, v_d;
  logic [WORD-1:0]   inst_q, inst_d;
  logic              accept, issue;
  logic              skid_v, skid_load, skid_drain, skid_flush;
  logic [WORD-1:0]   skid_data;
`ifdef IFETCH_PC_OUT_EN
  logic [W_ADDR-1:0] rsp_pc_q, rsp_pc_d;
  logic [W_ADDR-1:0] pc_out_q, pc_out_d;
  logic [W_ADDR-1:0] skid_pc;
`endif

  // Reads only go out when the output register can take their data, so the
  // skid never has to hold more than one word.
  assign accept      = ~v_q | ~stall_i;
  assign issue       = accept & ~br_taken_i & ~rst;
  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;

  always_comb begin
    pc_d       = pc_q;
    rsp_v_d    = issue;
    v_d        = v_q;
    inst_d     = inst_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_flush = br_taken_i;
`ifdef IFETCH_PC_OUT_EN
    rsp_pc_d   = issue ? pc_q : rsp_pc_q;
    pc_out_d   = pc_out_q;
`endif
    if (br_taken_i) begin
      pc_d    = br_target_i;
      v_d     = 1'b0;
      rsp_v_d = 1'b0;
    end else begin
      if (issue) begin
        pc_d = pc_q + 1'b1;
      end
      if (accept) begin
        if (skid_v) begin
          v_d        = 1'b1;
          inst_d     = skid_data;
          skid_drain = 1'b1;
`ifdef IFETCH_PC_OUT_EN
          pc_out_d   = skid_pc;
`endif
        end else if (rsp_v_q) begin
          v_d      = 1'b1;
          inst_d   = imem_data_i;
`ifdef IFETCH_PC_OUT_EN
          pc_out_d = rsp_pc_q;
`endif
        end else begin
          v_d = 1'b0;
        end
      end else if (rsp_v_q) begin
        skid_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RST_PC;
      rsp_v_q  <= 1'b0;
      v_q      <= 1'b0;
      inst_q   <= '0;
`ifdef IFETCH_PC_OUT_EN
      rsp_pc_q <= RST_PC;
      pc_out_q <= RST_PC;
`endif
    end else begin
      pc_q     <= pc_d;
      rsp_v_q  <= rsp_v_d;
      v_q      <= v_d;
      inst_q   <= inst_d;
`ifdef IFETCH_PC_OUT_EN
      rsp_pc_q <= rsp_pc_d;
      pc_out_q <= pc_out_d;
`endif
    end
  end

  ifetch_skid #(
    .WORD   (WORD)
`ifdef IFETCH_PC_OUT_EN
    ,
    .W_ADDR (W_ADDR)
`endif
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush_i (skid_flush),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .data_i  (imem_data_i),
`ifdef IFETCH_PC_OUT_EN
    .pc_i    (rsp_pc_q),
    .pc_o    (skid_pc),
`endif
    .v_o     (skid_v),
    .data_o  (skid_data)
  );

  assign v_o    = v_q;
  assign inst_o = inst_q;
`ifdef IFETCH_PC_OUT_EN
  assign pc_o   = pc_out_q;
`endif

  a_single_buffer: assert property (@(posedge clk) disable iff (rst) !(rsp_v_q && skid_v));

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard bench for ifetch (reset, stall/skid, branch, PC wrap, mid-stall reset)
// Builds with or without IFETCH_PC_OUT_EN.
module tb_ifetch;

  localparam int WORD   = 32;
  localparam int W_ADDR = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, br_taken, stall;
  logic [W_ADDR-1:0] br_target;
  logic              imem_req, v;
  logic [W_ADDR-1:0] imem_addr;
  logic [WORD-1:0]   imem_data, inst;

  logic              rst2, br_taken2, stall2;
  logic [W_ADDR-1:0] br_target2;
  logic              imem_req2, v2;
  logic [W_ADDR-1:0] imem_addr2;
  logic [WORD-1:0]   imem_data2, inst2;
`ifdef IFETCH_PC_OUT_EN
  logic [W_ADDR-1:0] pc, pc2;
`endif

  ifetch dut (
    .clk(clk), .rst(rst), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_data_i(imem_data), .br_taken_i(br_taken), .br_target_i(br_target),
    .v_o(v), .inst_o(inst),
`ifdef IFETCH_PC_OUT_EN
    .pc_o(pc),
`endif
    .stall_i(stall)
  );

  ifetch #(.RESET_PC(32'hFFFE)) dut2 (
    .clk(clk), .rst(rst2), .imem_req_o(imem_req2), .imem_addr_o(imem_addr2),
    .imem_data_i(imem_data2), .br_taken_i(br_taken2), .br_target_i(br_target2),
    .v_o(v2), .inst_o(inst2),
`ifdef IFETCH_PC_OUT_EN
    .pc_o(pc2),
`endif
    .stall_i(stall2)
  );

  // Synchronous imem model: word at address a reads as a+0x100
  always @(posedge clk) imem_data  <= imem_req  ? (32'(imem_addr)  + 32'h100) : 32'hDEADBEEF;
  always @(posedge clk) imem_data2 <= imem_req2 ? (32'(imem_addr2) + 32'h100) : 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] inst;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [15:0] exp5 [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_run(input logic [15:0] a0, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = a0 + 16'(i);
      e.inst = 32'(e.pc) + 32'h100;
      sb.push_back(e);
    end
  endtask

  // Inputs are final when this is called; a transfer to ID is any cycle with v_o & ~stall_i
  task automatic tick;
    exp_t e;
    #1;
    if (!rst && v && !stall) begin
      if (sb.size() == 0) begin
        check("sb_underflow", inst, 32'(sb.size()));
      end else begin
        e = sb.pop_front();
        check("inst", inst, e.inst);
`ifdef IFETCH_PC_OUT_EN
        check("pc_o", 32'(pc), 32'(e.pc));
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_inst(input string tag, input logic [31:0] want);
    int n = 0;
    while (!(v === 1'b1 && inst === want) && n < 64) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 64), 32'd1);
  endtask

  task automatic wait_req(input string tag, input logic [15:0] a);
    int n = 0;
    while (!(imem_req === 1'b1 && imem_addr === a) && n < 64) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 64), 32'd1);
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    stall    = 1'b0;
    br_taken = 1'b0;
    tick();
    tick();
    sb.delete();
    check("rst_v", 32'(v), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
`ifdef IFETCH_PC_OUT_EN
    check("rst_pc_o", 32'(pc), 32'd0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    rst2 = 1'b1; stall2 = 1'b0; br_taken2 = 1'b0; br_target2 = '0;
    exp5[0] = 16'hFFFE; exp5[1] = 16'hFFFF; exp5[2] = 16'h0000;
    exp5[3] = 16'h0001; exp5[4] = 16'h0002; exp5[5] = 16'h0003;
    @(negedge clk);

    // 1: streaming after reset, two-cycle first latency
    do_reset();
    push_run(16'h0, 8);
    #1;
    check("t1_req0", 32'(imem_req), 32'd1);
    check("t1_addr0", 32'(imem_addr), 32'd0);
    tick();
    check("t1_addr1", 32'(imem_addr), 32'd1);
    check("t1_v_cycle1", 32'(v), 32'd0);
    tick();
    check("t1_v_cycle2", 32'(v), 32'd1);
    check("t1_first_inst", inst, 32'h100);

    // 2: three stall cycles on 0x103, skid holds one word, release without bubble
    wait_inst("t2_wait_103", 32'h103);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t2_noreq", 32'(imem_req), 32'd0);
      check("t2_hold", inst, 32'h103);
      if (c > 0) check("t2_skid_full", 32'(dut.u_skid.v_o), 32'd1);
      tick();
    end
    stall = 1'b0;
    tick();
    check("t2_after_release", inst, 32'h104);
    tick();
    check("t2_no_bubble", inst, 32'h105);
    wait_inst("t2_wait_107", 32'h107);
    tick();
    check("t2_sb_left", 32'(sb.size()), 32'd0);

    // 3: branch to 0x40 while word 5 is in flight
    do_reset();
    push_run(16'h0, 5);
    push_run(16'h40, 2);
    wait_req("t3_wait_req6", 16'h6);
    check("t3_inst_at_br", inst, 32'h104);
    br_taken  = 1'b1;
    br_target = 16'h40;
    #1;
    check("t3_br_noreq", 32'(imem_req), 32'd0);
    tick();
    br_taken = 1'b0;
    #1;
    check("t3_tgt_req", 32'(imem_req), 32'd1);
    check("t3_tgt_addr", 32'(imem_addr), 32'h40);
    check("t3_v_gap1", 32'(v), 32'd0);
    tick();
    check("t3_v_gap2", 32'(v), 32'd0);
    tick();
    check("t3_tgt_v", 32'(v), 32'd1);
    check("t3_tgt_inst", inst, 32'h140);
    wait_inst("t3_wait_141", 32'h141);
    tick();
    check("t3_sb_left", 32'(sb.size()), 32'd0);

    // 4: branch while stalled with the skid full
    check("t4_start_inst", inst, 32'h142);
    stall = 1'b1;
    tick();
    check("t4_skid_full", 32'(dut.u_skid.v_o), 32'd1);
    check("t4_hold", inst, 32'h142);
    br_taken  = 1'b1;
    br_target = 16'h40;
    tick();
    br_taken = 1'b0;
    stall    = 1'b0;
    #1;
    check("t4_skid_flushed", 32'(dut.u_skid.v_o), 32'd0);
    check("t4_v_killed", 32'(v), 32'd0);
    check("t4_tgt_req", 32'(imem_req), 32'd1);
    check("t4_tgt_addr", 32'(imem_addr), 32'h40);
    push_run(16'h40, 2);
    tick();
    tick();
    check("t4_tgt_v", 32'(v), 32'd1);
    check("t4_tgt_inst", inst, 32'h140);
    wait_inst("t4_wait_141", 32'h141);
    tick();
    check("t4_sb_left", 32'(sb.size()), 32'd0);

    // 6: reset pulsed while stalled with a word in the skid
    do_reset();
    push_run(16'h0, 3);
    wait_inst("t6_wait_102", 32'h102);
    stall = 1'b1;
    tick();
    check("t6_skid_full", 32'(dut.u_skid.v_o), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_noreq", 32'(imem_req), 32'd0);
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    sb.delete();
    #1;
    check("t6_v", 32'(v), 32'd0);
    check("t6_skid", 32'(dut.u_skid.v_o), 32'd0);
    check("t6_req", 32'(imem_req), 32'd1);
    check("t6_addr", 32'(imem_addr), 32'd0);
`ifdef IFETCH_PC_OUT_EN
    check("t6_pc_o", 32'(pc), 32'd0);
`endif
    push_run(16'h0, 3);
    wait_inst("t6_wait_102b", 32'h102);
    tick();
    check("t6_sb_left", 32'(sb.size()), 32'd0);

    // 5: RESET_PC=0xFFFE wraps through 0x0000
    rst = 1'b1;
    tick();
    rst2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t5_req", 32'(imem_req2), 32'd1);
      check("t5_addr", 32'(imem_addr2), 32'(exp5[i]));
      check("t5_addr_x", 32'($isunknown(imem_addr2)), 32'd0);
      if (i >= 2) begin
        check("t5_v", 32'(v2), 32'd1);
        check("t5_inst", inst2, 32'(exp5[i-2]) + 32'h100);
`ifdef IFETCH_PC_OUT_EN
        check("t5_pc_o", 32'(pc2), 32'(exp5[i-2]));
`endif
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
